// File: rtl/noc_packetizer.sv
`timescale 1ns/1ps
// Source-side NoC network interface: turns a request (destination) plus
// FlitPerPacket-1 payload words into a HEAD/BODY/TAIL flit stream for a router's local port.
module noc_packetizer #(
   parameter int N             = 6,
   parameter int INDEX         = 0,
   parameter int DATA_WIDTH    = 32,
   parameter int TYPE_WIDTH    = 2,
   parameter int FlitPerPacket = 6,
   parameter int CNT_WIDTH     = 16,
   localparam int DEST_W       = $clog2(N)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DEST_W-1:0]                req_dest,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [DATA_WIDTH-TYPE_WIDTH-1:0] pld_data,
   input  logic                             pld_valid,
   output logic                             pld_ready,
   output logic [DATA_WIDTH-1:0]            flit_data,
   output logic                             flit_valid,
   input  logic                             flit_ready,
   output logic                             busy,
   output logic                             drop_pulse,
   output logic [CNT_WIDTH-1:0]             pkt_count
);

   localparam int PW     = DATA_WIDTH - TYPE_WIDTH;
   localparam int BEAT_W = $clog2(FlitPerPacket);
   localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(FlitPerPacket - 2);
   localparam logic [TYPE_WIDTH-1:0] TYPE_HEAD = TYPE_WIDTH'(1);
   localparam logic [TYPE_WIDTH-1:0] TYPE_BODY = TYPE_WIDTH'(2);
   localparam logic [TYPE_WIDTH-1:0] TYPE_TAIL = TYPE_WIDTH'(3);
   localparam logic [DEST_W-1:0]     SRC_ID    = DEST_W'(INDEX);

   // busy is the externally visible copy of the state (high only in S_PAYLOAD).
   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PAYLOAD = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [BEAT_W-1:0]     beat_cnt;
   logic                  load_ok;
   logic                  req_fire;
   logic                  pld_fire;
   logic                  dest_ok;
   logic                  last_beat;
   logic                  load_head;
   logic                  load_pld;
   logic                  drop_req;
   logic [DATA_WIDTH-1:0] head_flit;
   logic [DATA_WIDTH-1:0] flit_nxt;

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // valid never waits on ready, and ready may depend combinationally on the output register.
   assign load_ok   = !flit_valid || flit_ready;
   assign req_fire  = req_valid && req_ready;
   assign pld_fire  = pld_valid && pld_ready;
   assign dest_ok   = int'(req_dest) < N;
   assign last_beat = (beat_cnt == LAST_BEAT);
   assign load_head = (state == S_IDLE) && req_fire && dest_ok;
   assign drop_req  = (state == S_IDLE) && req_fire && !dest_ok;
   assign load_pld  = (state == S_PAYLOAD) && pld_fire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (load_head) state_nxt = S_PAYLOAD;
         S_PAYLOAD: if (load_pld && last_beat) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      pld_ready = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE:    req_ready = load_ok;
         S_PAYLOAD: begin
            pld_ready = load_ok;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // Head layout: type, destination, source, then zero padding down to bit 0.
   always_comb begin
      head_flit                                  = '0;
      head_flit[DATA_WIDTH-1 -: TYPE_WIDTH]      = TYPE_HEAD;
      head_flit[PW-1 -: DEST_W]                  = req_dest;
      head_flit[PW-DEST_W-1 -: DEST_W]           = SRC_ID;
   end

   always_comb begin
      if (load_head) begin
         flit_nxt = head_flit;
      end else begin
         flit_nxt = {(last_beat ? TYPE_TAIL : TYPE_BODY), pld_data};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flit_valid <= 1'b0;
         flit_data  <= '0;
         beat_cnt   <= '0;
         pkt_count  <= '0;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= drop_req;
         if (load_head || load_pld) begin
            flit_valid <= 1'b1;
            flit_data  <= flit_nxt;
         end else if (flit_ready) begin
            flit_valid <= 1'b0;
         end
         if (load_head) begin
            beat_cnt <= '0;
         end else if (load_pld) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
         end
         if (load_pld && last_beat) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule
